// File: rtl/mul16u_arb_sched_if.sv
// Request/response bus for the shared approximate multiplier.
// The master side is the requesters plus the result consumer; the slave side is the multiplier.
interface mul16u_arb_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_z;
    logic [ID_W-1:0]     rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_id
    );
endinterface

// File: rtl/mul16u_arb_sched.sv
// Round-robin shared 16x16 truncated multiplier with a two-stage stallable pipeline.
// S1 holds granted operands, S2 holds the product and drives the response port.
module mul16u_arb_sched #(
    parameter int N_REQ = 4,
    parameter int TRUNC = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    mul16u_arb_sched_if.slave bus,
    output logic              busy,
    output logic [15:0]       op_count
);
    localparam int              ID_W    = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic            s1_valid_q, s1_valid_d;
    logic [15:0]     s1_a_q, s1_a_d;
    logic [15:0]     s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [31:0]     s2_z_q, s2_z_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [15:0]     op_count_q, op_count_d;

    logic             advance;
    logic             accept;
    logic             rsp_fire;
    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic [N_REQ-1:0] grant_vec;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic [31:0]      a_trunc;
    logic [31:0]      b_trunc;
    logic [31:0]      product;

    assign advance  = !(s2_valid_q && !bus.rsp_ready);
    assign accept   = grant_any && advance;
    assign rsp_fire = s2_valid_q && bus.rsp_ready;

    // Search starts just after the last granted requester and wraps around.
    always_comb begin : arbiter
        int tgt;
        tgt       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        grant_vec = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int o = 0; o < N_REQ; o++) begin
            tgt = int'(last_grant_q) + 1 + o;
            if (tgt >= N_REQ) begin
                tgt = tgt - N_REQ;
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_any && (k == tgt) && bus.req_valid[k]) begin
                    grant_any    = 1'b1;
                    grant_id     = ID_W'(k);
                    grant_vec[k] = 1'b1;
                    sel_a        = bus.req_a[16*k +: 16];
                    sel_b        = bus.req_b[16*k +: 16];
                end
            end
        end
    end

    // Ready is forced low while reset is asserted so nothing looks accepted.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = grant_vec[gi] && advance && rst_n;
        end
    endgenerate

    assign a_trunc = {16'd0, s1_a_q >> TRUNC};
    assign b_trunc = {16'd0, s1_b_q >> TRUNC};
    assign product = (a_trunc * b_trunc) << (2 * TRUNC);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s2_valid_q;
        s2_z_d       = s2_z_q;
        s2_id_d      = s2_id_q;
        last_grant_d = last_grant_q;
        op_count_d   = op_count_q;

        if (advance) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d  = sel_a;
                s1_b_d  = sel_b;
                s1_id_d = grant_id;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_z_d  = product;
                s2_id_d = s1_id_q;
            end
        end

        if (accept) begin
            last_grant_d = grant_id;
        end

        if (rsp_fire && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_z_q       <= '0;
            s2_id_q      <= '0;
            last_grant_q <= LAST_ID;
            op_count_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_z_q       <= s2_z_d;
            s2_id_q      <= s2_id_d;
            last_grant_q <= last_grant_d;
            op_count_q   <= op_count_d;
        end
    end

    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_z     = s2_z_q;
    assign bus.rsp_id    = s2_id_q;
    assign busy          = s1_valid_q || s2_valid_q;
    assign op_count      = op_count_q;
endmodule

// File: tb/tb_mul16u_arb_sched.sv
// Bench for mul16u_arb_sched: a queue-level model of in-flight operations is checked
// against the DUT every falling edge; directed scenarios pin results with literal values.
module tb_mul16u_arb_sched;
    localparam int N = 4;
    localparam int T = 7;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    mul16u_arb_sched_if #(.N_REQ(N)) bus ();

    mul16u_arb_sched #(.N_REQ(N), .TRUNC(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {int id; logic [15:0] a; logic [15:0] b;} req_t;
    typedef struct {logic [31:0] z; int id; int age;} fl_t;
    typedef struct {logic [31:0] z; int id;} res_t;

    req_t pend[$];
    fl_t  flight[$];
    res_t dut_log[$];
    int   last_grant = N - 1;
    int   m_count    = 0;
    int   checks     = 0;
    int   failures   = 0;
    int   acc_count  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_z(input logic [15:0] a, input logic [15:0] b);
        int unsigned ah;
        int unsigned bh;
        ah = a >> T;
        bh = b >> T;
        return 32'((ah * bh) << (2 * T));
    endfunction

    function automatic int model_grant();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last_grant + k) % N;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit model_rv();
        return (flight.size() > 0) && (flight[0].age == 2);
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (!rst_n) return r;
        if (model_rv() && !bus.rsp_ready) return r;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic push(input int id, input logic [15:0] a, input logic [15:0] b);
        req_t e;
        e.id = id;
        e.a  = a;
        e.b  = b;
        pend.push_back(e);
    endtask

    // Model: an op ages one step per advancing edge and is presented once it reaches age 2.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            flight.delete();
            last_grant = N - 1;
            m_count    = 0;
        end else begin
            bit rv;
            bit adv;
            int g;
            rv  = model_rv();
            adv = !(rv && !bus.rsp_ready);
            g   = model_grant();
            if (rv && bus.rsp_ready) begin
                void'(flight.pop_front());
                if (m_count < 65535) m_count++;
            end
            if (adv) begin
                foreach (flight[i]) flight[i].age++;
                if (g >= 0) begin
                    fl_t e;
                    e.z   = model_z(bus.req_a[16*g +: 16], bus.req_b[16*g +: 16]);
                    e.id  = g;
                    e.age = 1;
                    flight.push_back(e);
                    last_grant = g;
                    for (int i = 0; i < pend.size(); i++) begin
                        if (pend[i].id == g) begin
                            pend.delete(i);
                            break;
                        end
                    end
                end
            end
        end
    end

    // Requesters present their oldest pending op, holding it until accepted.
    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        forever begin
            logic [N-1:0]   v;
            logic [16*N-1:0] va;
            logic [16*N-1:0] vb;
            @(posedge clk);
            #2;
            v  = '0;
            va = '0;
            vb = '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < pend.size(); j++) begin
                    if (pend[j].id == i) begin
                        v[i]          = 1'b1;
                        va[16*i +: 16] = pend[j].a;
                        vb[16*i +: 16] = pend[j].b;
                        break;
                    end
                end
            end
            bus.req_valid = v;
            bus.req_a     = va;
            bus.req_b     = vb;
        end
    end

    // Per-cycle comparison against the model, plus logging of DUT handshakes.
    initial forever begin
        bit rv;
        @(negedge clk);
        rv = model_rv();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
        chk("busy", 32'(busy), 32'(flight.size() > 0));
        chk("op_count", 32'(op_count), 32'(m_count));
        chk("req_ready", 32'(bus.req_ready), 32'(model_ready()));
        if (rv) begin
            chk("rsp_z", bus.rsp_z, flight[0].z);
            chk("rsp_id", 32'(bus.rsp_id), 32'(flight[0].id));
        end else if (!rst_n) begin
            chk("rst_rsp_z", bus.rsp_z, 32'd0);
            chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            res_t r;
            r.z  = bus.rsp_z;
            r.id = int'(bus.rsp_id);
            dut_log.push_back(r);
        end
        acc_count += $countones(bus.req_valid & bus.req_ready);
    end

    task automatic sync(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while ((pend.size() != 0 || busy) && n < budget) begin
            sync(1);
            n++;
        end
        chk({nm, "_idle"}, 32'(busy || (pend.size() != 0)), 32'd0);
    endtask

    task automatic log_id(input string nm, input int idx, input int exp_id);
        if (idx < dut_log.size()) chk(nm, 32'(dut_log[idx].id), 32'(exp_id));
        else chk({nm, "_missing"}, 32'(dut_log.size()), 32'(idx + 1));
    endtask

    task automatic log_z(input string nm, input int idx, input logic [31:0] exp_z);
        if (idx < dut_log.size()) chk(nm, dut_log[idx].z, exp_z);
        else chk({nm, "_missing"}, 32'(dut_log.size()), 32'(idx + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc0;
        int n;
        bus.rsp_ready = 1'b1;

        // Reset with a request already pending: nothing may be accepted until release.
        push(0, 16'hFFFF, 16'hFFFF);
        sync(3);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;

        // Full-scale operands, latency pinned edge by edge.
        @(negedge clk);
        chk("t1_accept", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_early_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_z", bus.rsp_z, 32'hFF004000);
        chk("t1_id", 32'(bus.rsp_id), 32'd0);
        @(negedge clk);
        chk("t1_op_count", 32'(op_count), 32'd1);

        // Truncation boundary cases.
        sync(1);
        push(1, 16'h0080, 16'h0080);
        push(2, 16'h007F, 16'hFFFF);
        wait_idle("t2", 30);
        log_z("t2_z_min", 1, 32'h00004000);
        log_id("t2_id_a", 1, 1);
        log_z("t2_z_zero", 2, 32'h00000000);
        log_id("t2_id_b", 2, 2);
        chk("t2_op_count", 32'(op_count), 32'd3);

        // Asynchronous reset with two operations in flight.
        sync(1);
        bus.rsp_ready = 1'b0;
        push(0, 16'h1234, 16'h5678);
        push(1, 16'h8000, 16'h4000);
        sync(4);
        chk("t4_busy_before", 32'(busy), 32'd1);
        chk("t4_valid_before", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        pend.delete();
        #1;
        chk("t4_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_count", 32'(op_count), 32'd0);
        chk("t4_rst_z", bus.rsp_z, 32'd0);
        base = dut_log.size();
        sync(2);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        sync(5);
        chk("t4_no_stale", 32'(dut_log.size()), 32'(base));
        chk("t4_busy_after", 32'(busy), 32'd0);

        // All requesters valid continuously: strict rotation from requester 0.
        base = dut_log.size();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                push(i, 16'(16'h2000 * i + 16'h0180 * (k + 1)), 16'(16'hF000 - 16'h0800 * i));
            end
        end
        wait_idle("t3", 60);
        for (int j = 0; j < 2 * N; j++) log_id($sformatf("t3_id%0d", j), base + j, j % N);

        // Consumer stall: only two operations may enter, then drain in order.
        sync(1);
        bus.rsp_ready = 1'b0;
        base = dut_log.size();
        acc0 = acc_count;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                push(i, 16'(16'h0100 * (i + 1) * (k + 1)), 16'h0200);
            end
        end
        sync(6);
        chk("t5_accepted", 32'(acc_count - acc0), 32'd2);
        chk("t5_ready_low", 32'(bus.req_ready), 32'd0);
        chk("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t5_hold_z", bus.rsp_z, 32'h00020000);
        chk("t5_hold_id", 32'(bus.rsp_id), 32'd0);
        bus.rsp_ready = 1'b1;
        wait_idle("t5", 60);
        for (int j = 0; j < 2 * N; j++) log_id($sformatf("t5_id%0d", j), base + j, j % N);

        // Pointer continues past the last grant: 2 first, then 3 before 1.
        sync(1);
        base = dut_log.size();
        push(2, 16'h0400, 16'h0400);
        n = 0;
        while (pend.size() != 0 && n < 10) begin
            sync(1);
            n++;
        end
        push(1, 16'h0300, 16'h0300);
        push(3, 16'h0500, 16'h0500);
        wait_idle("t6", 30);
        log_id("t6_first", base, 2);
        log_id("t6_second", base + 1, 3);
        log_id("t6_third", base + 2, 1);

        sync(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
